spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_master.sv | 185 ++++++++++++++++++
 tb/tb_spi_master.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Request/response and SPI pin bundle for spi_master.
// Modport slave is the spi_master side; master is its environment (requester plus SPI slave).
interface spi_master_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 start_i;
  logic [1:0]           cmd_i;
  logic [ADDR_SIZE-1:0] din_i;
  logic                 busy_o;
  logic                 done_o;
  logic [ADDR_SIZE-1:0] rd_data_o;
  logic                 err_o;
  logic                 ss_n_o;
  logic                 mosi_o;
  logic                 miso_i;

  modport master (
    output start_i, cmd_i, din_i, miso_i,
    input  busy_o, done_o, rd_data_o, err_o, ss_n_o, mosi_o
  );

  modport slave (
    input  start_i, cmd_i, din_i, miso_i,
    output busy_o, done_o, rd_data_o, err_o, ss_n_o, mosi_o
  );
endinterface

// File: rtl/spi_master.sv
// Command-framed SPI master: 2-bit command + ADDR_SIZE payload out, optional read-back.
// Optional read-address-before-read-data check enabled by `define SPI_MASTER_SEQ_CHECK_EN.
module spi_master #(
  parameter int ADDR_SIZE = 8,
  parameter int RD_WAIT   = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  bus
);

  localparam int FW      = ADDR_SIZE + 2;
  localparam int SH_W    = ADDR_SIZE - 1;
  localparam int CNT_MAX = (ADDR_SIZE > RD_WAIT) ? ADDR_SIZE : RD_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(ADDR_SIZE);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(ADDR_SIZE - 1);
  localparam logic [1:0]       CMD_RD_DATA = 2'b11;

  // Pin outputs are registered one cycle ahead: each state prepares the next
  // cycle's SS_n/MOSI/done, so the done cycle is already IDLE and a start seen
  // there opens the next frame after a single SS_n-high cycle.
  typedef enum logic [2:0] {IDLE, CMD, SHIFT, WAIT, READ, END} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]        frame_q, frame_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [SH_W-1:0]      shreg_q, shreg_d;
  logic [ADDR_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 ss_n_q, ss_n_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cap_q, cap_d;
  logic                 accept;
`ifdef SPI_MASTER_SEQ_CHECK_EN
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  logic                 err_q, err_d;
  logic                 seen_q, seen_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      cmd_q     <= '0;
      shreg_q   <= '0;
      rd_data_q <= '0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cap_q     <= 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      err_q     <= 1'b0;
      seen_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      cmd_q     <= cmd_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cap_q     <= cap_d;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      err_q     <= err_d;
      seen_q    <= seen_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    cmd_d     = cmd_q;
    shreg_d   = shreg_q;
    rd_data_d = rd_data_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cap_d     = 1'b0;
    accept    = bus.start_i;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    err_d     = 1'b0;
    seen_d    = seen_q;
`endif

    // cap_q marks the cycles whose closing edge samples MISO.
    if (cap_q) shreg_d = SH_W'({shreg_q, bus.miso_i});

    unique case (state_q)
      IDLE: begin
`ifdef SPI_MASTER_SEQ_CHECK_EN
        if (bus.cmd_i == CMD_RD_DATA && !seen_q) begin
          accept = 1'b0;
          err_d  = bus.start_i;
        end
`endif
        if (accept) begin
          frame_d = {bus.cmd_i, bus.din_i};
          cmd_d   = bus.cmd_i;
          ss_n_d  = 1'b0;
          mosi_d  = bus.cmd_i[1];
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        mosi_d  = frame_q[FW-1];
        state_d = SHIFT;
      end
      SHIFT: begin
        mosi_d  = frame_q[FW-2];
        frame_d = {frame_q[FW-2:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (cmd_q != CMD_RD_DATA) state_d = END;
          else if (RD_WAIT == 0)    state_d = READ;
          else                      state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        mosi_d = 1'b0;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        mosi_d = 1'b0;
        cap_d  = 1'b1;
        if (cnt_q == READ_LAST) begin
          cnt_d   = '0;
          state_d = END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      END: begin
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        // The last MISO bit is taken straight from the pin on this edge.
        if (cmd_q == CMD_RD_DATA) rd_data_d = {shreg_q, bus.miso_i};
`ifdef SPI_MASTER_SEQ_CHECK_EN
        if (cmd_q == CMD_RD_ADDR)      seen_d = 1'b1;
        else if (cmd_q == CMD_RD_DATA) seen_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.rd_data_o = rd_data_q;
  assign bus.ss_n_o    = ss_n_q;
  assign bus.mosi_o    = mosi_q;
`ifdef SPI_MASTER_SEQ_CHECK_EN
  assign bus.err_o     = err_q;
`else
  assign bus.err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of whole frames plus hand sequences
// for start-while-busy, mid-frame reset, read-data after reset and back-to-back frames.
module tb_spi_master;
  localparam int AW           = 8;
  localparam int RW           = 2;
  localparam int WR_LEN       = AW + 3;
  localparam int RD_LEN       = AW + 3 + RW + AW;
  localparam int FIRST_SAMPLE = AW + 3 + RW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_if #(.ADDR_SIZE(AW)) bus ();

  spi_master #(.ADDR_SIZE(AW), .RD_WAIT(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  din;
    logic [7:0]  miso_byte;
    logic [31:0] exp_mosi;
    int          exp_len;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected MOSI stream while SS_n is low: command MSB doubled, then the frame, then zeros.
  function automatic logic [31:0] mosi_model(input logic [1:0] c, input logic [7:0] d);
    logic [31:0] w;
    w = {21'b0, c[1], c, d};
    if (c == 2'b11) w = w << (RW + AW);
    return w;
  endfunction

  // Entered mid-cycle; returns mid-cycle of the done cycle (or after the budget expires).
  task automatic run_frame(input string tag, input logic [1:0] c, input logic [7:0] d,
                           input logic [7:0] mbyte, input int poke_at,
                           input int exp_len, input logic [31:0] exp_bits);
    int          len, done_at, busy_gaps, errs;
    logic [31:0] bits;
    logic        t0_ss_n;
    bus.start_i = 1'b1;
    bus.cmd_i   = c;
    bus.din_i   = d;
    @(posedge clk);
    len = 0; done_at = -1; busy_gaps = 0; errs = 0; bits = '0; t0_ss_n = 1'b1;
    for (int k = 0; k < 80 && done_at < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start_i = 1'b0;
        t0_ss_n     = bus.ss_n_o;
      end
      if (k == poke_at) begin
        bus.start_i = 1'b1;
        bus.cmd_i   = 2'b11;
        bus.din_i   = 8'hFF;
      end
      if (k == poke_at + 1) bus.start_i = 1'b0;
      if (!bus.ss_n_o) begin
        len++;
        bits = {bits[30:0], bus.mosi_o};
      end
      if (bus.err_o) errs++;
      if (bus.done_o) done_at = k;
      else if (!bus.busy_o) busy_gaps++;
      bus.miso_i = (k >= FIRST_SAMPLE && k < FIRST_SAMPLE + AW) ?
                   mbyte[AW-1-(k-FIRST_SAMPLE)] : 1'b0;
    end
    check({tag, ".t0_ss_n"}, 32'(t0_ss_n), 32'd0);
    check({tag, ".ss_low_len"}, len, exp_len);
    check({tag, ".done_at"}, done_at, exp_len);
    check({tag, ".mosi_bits"}, bits, exp_bits);
    check({tag, ".busy_gaps"}, busy_gaps, 0);
    check({tag, ".err_seen"}, errs, 0);
    check({tag, ".done_ss_n"}, 32'(bus.ss_n_o), 32'd1);
    check({tag, ".done_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, ".done_mosi"}, 32'(bus.mosi_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b, cnt_c;

    // Write-addr 10, write-data 3C, read-addr 10, read-data returns 3C, and so on.
    vecs[0] = '{2'b00, 8'hA5, 8'h00, 32'h0A5,    WR_LEN, 8'h00};
    vecs[1] = '{2'b00, 8'h10, 8'h00, 32'h010,    WR_LEN, 8'h00};
    vecs[2] = '{2'b01, 8'h3C, 8'h00, 32'h13C,    WR_LEN, 8'h00};
    vecs[3] = '{2'b10, 8'h10, 8'h00, 32'h610,    WR_LEN, 8'h00};
    vecs[4] = '{2'b11, 8'h00, 8'h3C, 32'h1C0000, RD_LEN, 8'h3C};
    vecs[5] = '{2'b00, 8'hFF, 8'h00, 32'h0FF,    WR_LEN, 8'h3C};
    vecs[6] = '{2'b10, 8'h5A, 8'h00, 32'h65A,    WR_LEN, 8'h3C};
    vecs[7] = '{2'b11, 8'h81, 8'hC3, 32'h1E0400, RD_LEN, 8'hC3};
    vecs[8] = '{2'b01, 8'h00, 8'h00, 32'h100,    WR_LEN, 8'hC3};

    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.cmd_i   = 2'b00;
    bus.din_i   = 8'h00;
    bus.miso_i  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.ss_n",    32'(bus.ss_n_o),   32'd1);
    check("reset.mosi",    32'(bus.mosi_o),   32'd0);
    check("reset.busy",    32'(bus.busy_o),   32'd0);
    check("reset.done",    32'(bus.done_o),   32'd0);
    check("reset.err",     32'(bus.err_o),    32'd0);
    check("reset.rd_data", 32'(bus.rd_data_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table frames run back to back: each start is raised in the previous done cycle.
    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].din, vecs[i].miso_byte, -1,
                vecs[i].exp_len, vecs[i].exp_mosi);
      check($sformatf("vec%0d.rd_data", i), 32'(bus.rd_data_o), 32'(vecs[i].exp_rd));
    end

    // Back-to-back: the done cycle is the only SS_n-high cycle before the next T0.
    check("b2b.gap_ss_n", 32'(bus.ss_n_o), 32'd1);
    run_frame("b2b", 2'b00, 8'h81, 8'h00, -1, WR_LEN, mosi_model(2'b00, 8'h81));

    // Start pulsed at T5 of an active frame is neither honoured nor queued.
    run_frame("poke", 2'b01, 8'h5A, 8'h00, 5, WR_LEN, mosi_model(2'b01, 8'h5A));
    cnt_a = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!bus.ss_n_o || bus.done_o || bus.busy_o) cnt_a++;
    end
    check("poke.no_second_frame", cnt_a, 0);

    // Reset at T6 of a read-data frame (preceded by a read-address frame).
    run_frame("rst_ra", 2'b10, 8'h22, 8'h00, -1, WR_LEN, mosi_model(2'b10, 8'h22));
    bus.start_i = 1'b1;
    bus.cmd_i   = 2'b11;
    bus.din_i   = 8'h00;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid.ss_n_before", 32'(bus.ss_n_o), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid.ss_n",    32'(bus.ss_n_o),    32'd1);
    check("rst_mid.busy",    32'(bus.busy_o),    32'd0);
    check("rst_mid.done",    32'(bus.done_o),    32'd0);
    check("rst_mid.rd_data", 32'(bus.rd_data_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_b = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done_o || !bus.ss_n_o || bus.busy_o) cnt_b++;
    end
    check("rst_mid.quiet_after", cnt_b, 0);

    // Read-data as the first frame after reset.
`ifdef SPI_MASTER_SEQ_CHECK_EN
    bus.start_i = 1'b1;
    bus.cmd_i   = 2'b11;
    bus.din_i   = 8'h44;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    check("rd_after_rst.err",  32'(bus.err_o),  32'd1);
    check("rd_after_rst.ss_n", 32'(bus.ss_n_o), 32'd1);
    check("rd_after_rst.busy", 32'(bus.busy_o), 32'd0);
    cnt_c = 0;
    for (int k = 0; k < RD_LEN + 3; k++) begin
      @(negedge clk);
      if (!bus.ss_n_o || bus.done_o || bus.err_o || bus.busy_o) cnt_c++;
    end
    check("rd_after_rst.quiet", cnt_c, 0);
    run_frame("post_rst", 2'b00, 8'hC7, 8'h00, -1, WR_LEN, mosi_model(2'b00, 8'hC7));
    check("post_rst.rd_data", 32'(bus.rd_data_o), 32'h00);
`else
    cnt_c = 0;
    run_frame("rd_after_rst", 2'b11, 8'h44, 8'h96, -1, RD_LEN, mosi_model(2'b11, 8'h44));
    check("rd_after_rst.rd_data", 32'(bus.rd_data_o), 32'h96);
    run_frame("post_rst", 2'b00, 8'hC7, 8'h00, -1, WR_LEN, mosi_model(2'b00, 8'hC7));
    check("post_rst.rd_data", 32'(bus.rd_data_o), 32'h96);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
